switch_allocator: RTL and testbench

Per-router switch allocator for the 5-port, 2-VC mesh router. Each cycle it picks at most one VC per input port and at most one input port per output port, using separable input-first round-robin arbitration. It drives the crossbar select and the per-VC read grants. Optionally it holds an output for the whole packet, from HEAD through TAIL.

---
 rtl/switch_allocator_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/switch_allocator.sv | 172 +++++++++++++++++
 tb/tb_switch_allocator.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_allocator_pkg.sv
// Shared NoC router parameters and flit/port types (package noc_params).
package noc_params;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [PORT_SIZE-1:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer is the highest-priority index; on an update with a grant at
// index k the pointer moves to (k+1) mod N.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         update_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            win;
    int            idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        win     = 0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                win          = idx;
                grant_o[idx] = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (update_i && found) begin
            ptr_d = PW'((win + 1) % N);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator. Define SA_PACKET_LOCK_EN to hold an
// output from HEAD through TAIL of a packet.
module switch_allocator
    import noc_params::*;
#(
    parameter int PORT_NUM = noc_params::PORT_NUM,
    parameter int VC_NUM   = noc_params::VC_NUM
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]    req_i,
    input  port_t                              out_port_i [PORT_NUM][VC_NUM],
    input  flit_label_t                        label_i [PORT_NUM][VC_NUM],
    input  logic [PORT_NUM-1:0]                out_ready_i,
    output logic [PORT_NUM-1:0][VC_NUM-1:0]    grant_o,
    output logic [PORT_SIZE-1:0]               xbar_sel_o [PORT_NUM],
    output logic [PORT_NUM-1:0]                xbar_valid_o
);

    logic [PORT_NUM-1:0][VC_NUM-1:0]   elig;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   s1_gnt;
    logic [PORT_NUM-1:0]               cand_valid;
    port_t                             cand_port [PORT_NUM];
    logic [VC_SIZE-1:0]                cand_vc [PORT_NUM];
    logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;  // [output][input]
    logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_gnt;
    logic [PORT_NUM-1:0]               in_win;
    int                                dst;

`ifdef SA_PACKET_LOCK_EN
    logic [PORT_NUM-1:0] lock_valid_q, lock_valid_d;
    logic [PORT_SIZE-1:0] lock_in_q [PORT_NUM];
    logic [PORT_SIZE-1:0] lock_in_d [PORT_NUM];
    logic [VC_SIZE-1:0]   lock_vc_q [PORT_NUM];
    logic [VC_SIZE-1:0]   lock_vc_d [PORT_NUM];
`else
    logic unused_label;

    always_comb begin
        unused_label = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                unused_label = unused_label ^ (^label_i[i][v]);
            end
        end
    end
`endif

    always_comb begin
        elig = '0;
        dst  = 0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                dst = int'(out_port_i[i][v]);
                if (req_i[i][v] && dst < PORT_NUM) begin
                    elig[i][v] = out_ready_i[dst];
`ifdef SA_PACKET_LOCK_EN
                    // A held output admits only the VC that owns the packet in flight.
                    if (lock_valid_q[dst] &&
                        !(lock_in_q[dst] == PORT_SIZE'(i) && lock_vc_q[dst] == VC_SIZE'(v))) begin
                        elig[i][v] = 1'b0;
                    end
`endif
                end
            end
        end
    end

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_vc_arb
        rr_arbiter #(.N(VC_NUM)) u_vc_arb (
            .clk      (clk),
            .rst      (rst),
            .req_i    (elig[i]),
            .update_i (in_win[i]),
            .grant_o  (s1_gnt[i])
        );
    end

    always_comb begin
        s2_req = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            cand_valid[i] = |s1_gnt[i];
            cand_port[i]  = LOCAL;
            cand_vc[i]    = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                if (s1_gnt[i][v]) begin
                    cand_port[i] = out_port_i[i][v];
                    cand_vc[i]   = VC_SIZE'(v);
                end
            end
            for (int o = 0; o < PORT_NUM; o++) begin
                s2_req[o][i] = cand_valid[i] && (int'(cand_port[i]) == o);
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out_arb
        rr_arbiter #(.N(PORT_NUM)) u_out_arb (
            .clk      (clk),
            .rst      (rst),
            .req_i    (s2_req[o]),
            .update_i (1'b1),
            .grant_o  (s2_gnt[o])
        );
    end

    always_comb begin
        in_win       = '0;
        grant_o      = '0;
        xbar_valid_o = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            xbar_sel_o[o] = '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                if (s2_gnt[o][i]) begin
                    in_win[i]       = 1'b1;
                    xbar_valid_o[o] = 1'b1;
                    xbar_sel_o[o]   = PORT_SIZE'(i);
                end
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            if (in_win[i]) begin
                grant_o[i] = s1_gnt[i];
            end
        end
        if (rst) begin
            grant_o      = '0;
            xbar_valid_o = '0;
            for (int o = 0; o < PORT_NUM; o++) begin
                xbar_sel_o[o] = '0;
            end
        end
    end

`ifdef SA_PACKET_LOCK_EN
    always_comb begin
        lock_valid_d = lock_valid_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            lock_in_d[o] = lock_in_q[o];
            lock_vc_d[o] = lock_vc_q[o];
            for (int i = 0; i < PORT_NUM; i++) begin
                if (s2_gnt[o][i]) begin
                    if (label_i[i][cand_vc[i]] == HEAD) begin
                        lock_valid_d[o] = 1'b1;
                        lock_in_d[o]    = PORT_SIZE'(i);
                        lock_vc_d[o]    = cand_vc[i];
                    end else if (label_i[i][cand_vc[i]] == TAIL) begin
                        lock_valid_d[o] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_valid_q <= '0;
            for (int o = 0; o < PORT_NUM; o++) begin
                lock_in_q[o] <= '0;
                lock_vc_q[o] <= '0;
            end
        end else begin
            lock_valid_q <= lock_valid_d;
            for (int o = 0; o < PORT_NUM; o++) begin
                lock_in_q[o] <= lock_in_d[o];
                lock_vc_q[o] <= lock_vc_d[o];
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed scenarios plus randomized traffic
// against a behavioural allocation model.
module tb_switch_allocator;
    import noc_params::*;

`ifdef SA_PACKET_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [4:0][1:0]   req;
    port_t             op [5][2];
    flit_label_t       lb [5][2];
    logic [4:0]        rdy;
    logic [4:0][1:0]   grant;
    logic [2:0]        sel [5];
    logic [4:0]        valid;
    logic [4:0][2:0]   sel_flat;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_iptr [5];
    int m_optr [5];
    bit m_lk_v [5];
    int m_lk_i [5];
    int m_lk_vc [5];
    int m_cand [5];
    int m_win [5];
    logic [4:0][1:0] e_grant;
    logic [4:0]      e_valid;
    logic [4:0][2:0] e_sel;

    always #5 clk = ~clk;

    always_comb begin
        for (int o = 0; o < 5; o++) sel_flat[o] = sel[o];
    end

    switch_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .out_port_i   (op),
        .label_i      (lb),
        .out_ready_i  (rdy),
        .grant_o      (grant),
        .xbar_sel_o   (sel),
        .xbar_valid_o (valid)
    );

    task automatic clear_inputs();
        req = '0;
        rdy = '1;
        for (int i = 0; i < 5; i++) begin
            for (int v = 0; v < 2; v++) begin
                op[i][v] = LOCAL;
                lb[i][v] = HEADTAIL;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_iptr[k] = 0;
            m_optr[k] = 0;
            m_lk_v[k] = 0;
            m_lk_i[k] = 0;
            m_lk_vc[k] = 0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic bit model_elig(int i, int v);
        int o;
        o = int'(op[i][v]);
        if (!req[i][v] || o > 4 || !rdy[o]) return 0;
        if (LockEn && m_lk_v[o] && !(m_lk_i[o] == i && m_lk_vc[o] == v)) return 0;
        return 1;
    endfunction

    task automatic model_eval();
        e_grant = '0;
        e_valid = '0;
        e_sel   = '0;
        for (int i = 0; i < 5; i++) begin
            m_cand[i] = -1;
            for (int k = 0; k < 2; k++) begin
                if (m_cand[i] < 0 && model_elig(i, (m_iptr[i] + k) % 2)) m_cand[i] = (m_iptr[i] + k) % 2;
            end
        end
        for (int o = 0; o < 5; o++) begin
            m_win[o] = -1;
            for (int k = 0; k < 5; k++) begin
                int i;
                i = (m_optr[o] + k) % 5;
                if (m_win[o] < 0 && m_cand[i] >= 0 && int'(op[i][m_cand[i]]) == o) m_win[o] = i;
            end
            if (m_win[o] >= 0) begin
                e_valid[o] = 1'b1;
                e_sel[o] = 3'(m_win[o]);
                e_grant[m_win[o]][m_cand[m_win[o]]] = 1'b1;
            end
        end
    endtask

    task automatic model_commit();
        for (int o = 0; o < 5; o++) begin
            if (m_win[o] >= 0) begin
                int i;
                int v;
                i = m_win[o];
                v = m_cand[i];
                m_optr[o] = (i + 1) % 5;
                m_iptr[i] = (v + 1) % 2;
                if (LockEn && lb[i][v] == HEAD) begin
                    m_lk_v[o] = 1;
                    m_lk_i[o] = i;
                    m_lk_vc[o] = v;
                end else if (LockEn && lb[i][v] == TAIL) begin
                    m_lk_v[o] = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        req[1][0] = 1'b1;
        op[1][0] = EAST;
        #1;
        total++;
        if (grant !== '0) begin
            bad++;
            $display("FAIL reset_grant: got %h want 0", grant);
        end
        total++;
        if (valid !== '0) begin
            bad++;
            $display("FAIL reset_valid: got %b want 0", valid);
        end
        total++;
        if (sel_flat !== '0) begin
            bad++;
            $display("FAIL reset_sel: got %h want 0", sel_flat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [4:0][1:0] eg;
        do_reset();
        req[1][0] = 1'b1;
        op[1][0] = EAST;
        eg = '0;
        eg[1] = 2'b01;
        #1;
        total++;
        if (grant !== eg) begin
            bad++;
            $display("FAIL single_grant: got %h want %h", grant, eg);
        end
        total++;
        if (valid !== 5'b10000 || sel_flat[4] !== 3'd1) begin
            bad++;
            $display("FAIL single_xbar: got valid=%b sel=%0d want valid=10000 sel=1", valid, sel_flat[4]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rotate();
        int exp_w [4] = '{1, 2, 3, 1};
        logic [4:0][1:0] eg;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            req[i][0] = 1'b1;
            op[i][0] = EAST;
        end
        for (int c = 0; c < 4; c++) begin
            eg = '0;
            eg[exp_w[c]] = 2'b01;
            #1;
            total++;
            if (grant !== eg || sel_flat[4] !== 3'(exp_w[c]) || valid !== 5'b10000) begin
                bad++;
                $display("FAIL rotate_c%0d: got grant=%h sel=%0d valid=%b want grant=%h sel=%0d valid=10000",
                         c, grant, sel_flat[4], valid, eg, exp_w[c]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_vc_alternate();
        do_reset();
        req[0] = 2'b11;
        op[0][0] = EAST;
        op[0][1] = WEST;
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (grant[0] !== ((c % 2 == 0) ? 2'b01 : 2'b10) ||
                valid !== ((c % 2 == 0) ? 5'b10000 : 5'b01000)) begin
                bad++;
                $display("FAIL vc_alt_c%0d: got grant0=%b valid=%b want grant0=%b", c, grant[0], valid,
                         (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ready_stall();
        do_reset();
        req[1][0] = 1'b1;
        op[1][0] = EAST;
        req[2][0] = 1'b1;
        op[2][0] = EAST;
        rdy[4] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (grant !== '0 || valid !== '0) begin
                bad++;
                $display("FAIL stall_c%0d: got grant=%h valid=%b want 0", c, grant, valid);
            end
            @(posedge clk);
            #1;
        end
        rdy[4] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (sel_flat[4] !== 3'(c + 1) || valid !== 5'b10000 || grant[c + 1] !== 2'b01) begin
                bad++;
                $display("FAIL stall_resume_c%0d: got sel=%0d valid=%b want sel=%0d", c, sel_flat[4], valid,
                         c + 1);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_packet_lock();
        flit_label_t seq [3] = '{HEAD, BODY, TAIL};
        int exp_w [5];
        int n;
        if (LockEn) exp_w = '{1, 1, 1, 2, 2};
        else exp_w = '{1, 2, 1, 2, 1};
        do_reset();
        op[1][0] = EAST;
        req[2][0] = 1'b1;
        op[2][0] = EAST;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            req[1][0] = (n < 3);
            lb[1][0] = seq[(n < 3) ? n : 2];
            #1;
            total++;
            if (sel_flat[4] !== 3'(exp_w[c]) || valid[4] !== 1'b1 || grant[exp_w[c]] !== 2'b01) begin
                bad++;
                $display("FAIL packet_c%0d: got sel=%0d valid=%b want sel=%0d", c, sel_flat[4], valid,
                         exp_w[c]);
            end
            if (exp_w[c] == 1) n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req[1][0] = 1'b1;
        op[1][0] = EAST;
        lb[1][0] = HEAD;
        req[2][0] = 1'b1;
        op[2][0] = EAST;
        #1;
        total++;
        if (sel_flat[4] !== 3'd1 || valid[4] !== 1'b1) begin
            bad++;
            $display("FAIL midrst_head: got sel=%0d valid=%b want sel=1", sel_flat[4], valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        req[1][0] = 1'b0;
        #1;
        total++;
        if (grant !== '0 || valid !== '0) begin
            bad++;
            $display("FAIL midrst_forced: got grant=%h valid=%b want 0", grant, valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (sel_flat[4] !== 3'd2 || valid !== 5'b10000 || grant[2] !== 2'b01) begin
            bad++;
            $display("FAIL midrst_resume: got sel=%0d valid=%b grant=%h want sel=2", sel_flat[4], valid,
                     grant);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 5; i++) begin
                for (int v = 0; v < 2; v++) begin
                    req[i][v] = ($urandom_range(0, 9) < 6);
                    op[i][v] = ($urandom_range(0, 9) < 9) ? port_t'($urandom_range(0, 4))
                                                          : port_t'($urandom_range(5, 7));
                    lb[i][v] = flit_label_t'($urandom_range(0, 3));
                end
                rdy[i] = ($urandom_range(0, 99) < 85);
            end
            #1;
            model_eval();
            total++;
            if (grant !== e_grant) begin
                bad++;
                $display("FAIL rand_grant_c%0d: got %h want %h", c, grant, e_grant);
            end
            total++;
            if (valid !== e_valid) begin
                bad++;
                $display("FAIL rand_valid_c%0d: got %b want %b", c, valid, e_valid);
            end
            total++;
            if (sel_flat !== e_sel) begin
                bad++;
                $display("FAIL rand_sel_c%0d: got %h want %h", c, sel_flat, e_sel);
            end
            model_commit();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_rotate();
        test_vc_alternate();
        test_ready_stall();
        test_packet_lock();
        test_reset_mid_packet();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
